// File: rtl/rb_arbiter.sv
// rb_arbiter: round-robin two-requester sequencer for a single-port RB bank; define RB_ARB_WRPROT_EN to make requester 1 read-only.
// Latency: gnt on the request edge, bank command one edge after acceptance, read data one edge later; waiting requester held off by gnt, bursts capped at MAX_BURST.
module rb_arbiter #(
    parameter int DEPTH     = 18,
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       last0,
    input  logic       last1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic       err0,
    output logic       err1,
    output logic       RB_RW,
    output logic [4:0] RB_A,
    output logic [7:0] RB_D,
    input  logic [7:0] RB_Q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;
    localparam logic [5:0] DEPTH_W = 6'(DEPTH);
    localparam logic [7:0] CAP     = 8'(MAX_BURST);

    logic [1:0] state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic       rw_q, rw_d;
    logic [4:0] a_q, a_d;
    logic [7:0] d_q, d_d;
    logic       err0_q, err0_d, err1_q, err1_d;
    logic       pend0_q, pend0_d, pend1_q, pend1_d;
    logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Owner-side command mux: only one requester can own the bank at a time.
    logic       own1;
    logic       c_req, c_rw, c_last, o_req;
    logic [4:0] c_addr;
    logic [7:0] c_wdata;
    logic       acc, wr_block, illegal, legal_wr, legal_rd, release_own;
    logic [7:0] cnt_inc;

    assign own1    = (state_q == S_OWN1);
    assign c_req   = own1 ? req1   : req0;
    assign c_rw    = own1 ? rw1    : rw0;
    assign c_last  = own1 ? last1  : last0;
    assign c_addr  = own1 ? addr1  : addr0;
    assign c_wdata = own1 ? wdata1 : wdata0;
    assign o_req   = own1 ? req0   : req1;

    assign acc = ((state_q == S_OWN0) && req0 && gnt0_q) ||
                 ((state_q == S_OWN1) && req1 && gnt1_q);

`ifdef RB_ARB_WRPROT_EN
    assign wr_block = own1 && !c_rw;
`else
    assign wr_block = 1'b0;
`endif

    assign illegal  = ({1'b0, c_addr} >= DEPTH_W) || wr_block;
    assign legal_wr = acc && !illegal && !c_rw;
    assign legal_rd = acc && !illegal && c_rw;
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Dropped commands still count and still honour last, so a bad stream cannot hog the bank.
    assign release_own = (acc && c_last) || (acc && (cnt_inc >= CAP) && o_req) ||
                         (!c_req && o_req);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (req0 && (!req1 || last_owner_q)) begin
                    state_d = S_OWN0;
                    gnt0_d  = 1'b1;
                end else if (req1) begin
                    state_d = S_OWN1;
                    gnt1_d  = 1'b1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (acc) cnt_d = cnt_inc;
                if (release_own) begin
                    state_d      = S_IDLE;
                    gnt0_d       = 1'b0;
                    gnt1_d       = 1'b0;
                    last_owner_d = own1;
                    cnt_d        = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        rw_d      = !legal_wr;
        a_d       = (legal_wr || legal_rd) ? c_addr : a_q;
        d_d       = legal_wr ? c_wdata : d_q;
        err0_d    = acc && illegal && !own1;
        err1_d    = acc && illegal && own1;
        pend0_d   = legal_rd && !own1;
        pend1_d   = legal_rd && own1;
        rvalid0_d = pend0_q;
        rvalid1_d = pend1_q;
        rdata0_d  = pend0_q ? RB_Q : rdata0_q;
        rdata1_d  = pend1_q ? RB_Q : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            cnt_q        <= 8'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rw_q         <= 1'b1;
            a_q          <= 5'd0;
            d_q          <= 8'd0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            pend0_q      <= 1'b0;
            pend1_q      <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= 8'd0;
            rdata1_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rw_q         <= rw_d;
            a_q          <= a_d;
            d_q          <= d_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            pend0_q      <= pend0_d;
            pend1_q      <= pend1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign RB_RW   = rw_q;
    assign RB_A    = a_q;
    assign RB_D    = d_q;

endmodule

// File: tb/tb_rb_arbiter.sv
// Bench for rb_arbiter: directed stimulus pushes expected strobes (with their cycle) into per-channel queues; a monitor pops and compares.
module tb_rb_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b1, rw1 = 1'b1, last0 = 1'b0, last1 = 1'b0;
    logic [4:0] addr0 = 5'd0, addr1 = 5'd0;
    logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
    logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1, RB_RW;
    logic [7:0] rdata0, rdata1, RB_D, RB_Q;
    logic [4:0] RB_A;

    rb_arbiter #(.DEPTH(18), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .err0(err0), .err1(err1),
        .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .RB_Q(RB_Q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    ev_t q_wr[$], q_rd0[$], q_rd1[$], q_er0[$], q_er1[$], q_g0[$], q_g1[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    logic [7:0] bank [0:17];
    logic [7:0] ref_mem [0:17];

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: single port, combinational read, written on the edge that ends a write pulse.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 18; i++) bank[i] <= 8'(i * 7 + 3);
        end else if (!RB_RW && RB_A < 5'd18) begin
            bank[RB_A] <= RB_D;
        end
    end
    assign RB_Q = (RB_A < 5'd18) ? bank[RB_A] : 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: strobe at cycle %0d with nothing expected", nm, cyc);
    endtask

    function automatic ev_t mk(input logic [4:0] a, input logic [7:0] d, input int c);
        ev_t e;
        e.a = a; e.d = d; e.cyc = c;
        return e;
    endfunction

    task automatic exp_gnt(input int n, input int c);
        if (n == 0) q_g0.push_back(mk(5'd0, 8'd0, c));
        else        q_g1.push_back(mk(5'd0, 8'd0, c));
    endtask

    // Presents one command for exactly one edge; expectations assume the requester owns the bank.
    task automatic issue(input int n, input logic rw, input logic [4:0] a,
                         input logic [7:0] wd, input logic lst);
        int   e;
        logic bad;
        @(negedge clk);
        e = cyc + 1;
        if (n == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = wd; last0 = lst; end
        else        begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = wd; last1 = lst; end
        bad = (a >= 5'd18);
`ifdef RB_ARB_WRPROT_EN
        if (n == 1 && !rw) bad = 1'b1;
`endif
        if (bad) begin
            if (n == 0) q_er0.push_back(mk(a, 8'd0, e));
            else        q_er1.push_back(mk(a, 8'd0, e));
        end else if (!rw) begin
            ref_mem[a] = wd;
            q_wr.push_back(mk(a, wd, e));
        end else begin
            if (n == 0) q_rd0.push_back(mk(a, ref_mem[a], e + 1));
            else        q_rd1.push_back(mk(a, ref_mem[a], e + 1));
        end
    endtask

    // Monitor: every strobe the DUT shows must match the head of its queue, including cycle.
    initial begin
        ev_t  ev;
        logic g0p, g1p;
        g0p = 1'b0; g1p = 1'b0;
        forever begin
            @(negedge clk);
            if (!RB_RW) begin
                if (q_wr.size() == 0) unexp("wr_pulse");
                else begin
                    ev = q_wr.pop_front();
                    chk("wr_addr", RB_A, ev.a); chk("wr_data", RB_D, ev.d); chk("wr_cycle", cyc, ev.cyc);
                end
            end
            if (rvalid0) begin
                if (q_rd0.size() == 0) unexp("rvalid0");
                else begin ev = q_rd0.pop_front(); chk("rdata0", rdata0, ev.d); chk("rvalid0_cycle", cyc, ev.cyc); end
            end
            if (rvalid1) begin
                if (q_rd1.size() == 0) unexp("rvalid1");
                else begin ev = q_rd1.pop_front(); chk("rdata1", rdata1, ev.d); chk("rvalid1_cycle", cyc, ev.cyc); end
            end
            if (err0) begin
                if (q_er0.size() == 0) unexp("err0");
                else begin ev = q_er0.pop_front(); chk("err0_cycle", cyc, ev.cyc); end
            end
            if (err1) begin
                if (q_er1.size() == 0) unexp("err1");
                else begin ev = q_er1.pop_front(); chk("err1_cycle", cyc, ev.cyc); end
            end
            if (gnt0 && !g0p) begin
                if (q_g0.size() == 0) unexp("gnt0_rise");
                else begin ev = q_g0.pop_front(); chk("gnt0_rise_cycle", cyc, ev.cyc); end
            end
            if (gnt1 && !g1p) begin
                if (q_g1.size() == 0) unexp("gnt1_rise");
                else begin ev = q_g1.pop_front(); chk("gnt1_rise_cycle", cyc, ev.cyc); end
            end
            if (gnt0 && gnt1) unexp("both_gnt");
            g0p = gnt0; g1p = gnt1;
        end
    end

    initial begin
        for (int i = 0; i < 18; i++) ref_mem[i] = 8'(i * 7 + 3);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_RB_RW", RB_RW, 1); chk("rst_RB_A", RB_A, 0); chk("rst_RB_D", RB_D, 0);
        chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid", {rvalid0, rvalid1}, 0); chk("rst_err", {err0, err1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);

        // Tie on first edge after reset goes to requester 0
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        exp_gnt(0, cyc + 1);
        issue(0, 1'b0, 5'd5, 8'hA5, 1'b0);
        issue(0, 1'b1, 5'd5, 8'h00, 1'b1);
        @(negedge clk);
        chk("bubble_gnt0", gnt0, 0); chk("bubble_gnt1", gnt1, 0);
        exp_gnt(1, cyc + 1);

        // Requester 1 writes addr 3 (blocked when write-protected), then reads it back
        issue(1, 1'b0, 5'd3, 8'h3C, 1'b0);
        issue(1, 1'b1, 5'd3, 8'h00, 1'b1);
        @(negedge clk);
        chk("bubble2_gnt1", gnt1, 0);
        exp_gnt(0, cyc + 1);

        // Highest legal address reads; the next one is dropped
        issue(0, 1'b1, 5'd17, 8'h00, 1'b0);
        issue(0, 1'b1, 5'd18, 8'h00, 1'b1);
        @(negedge clk);
        chk("illegal_RB_A_hold", RB_A, 17); chk("illegal_RB_RW", RB_RW, 1);
        rw1 = 1'b1; addr1 = 5'd2; last1 = 1'b1;
        exp_gnt(1, cyc + 1);
        q_rd1.push_back(mk(5'd2, ref_mem[2], cyc + 3));
        exp_gnt(0, cyc + 3);
        repeat (2) @(negedge clk);

        // Fairness: requester 0 streams 20 reads with requester 1 waiting
        for (int k = 0; k < 8; k++) issue(0, 1'b1, 5'(k), 8'h00, 1'b0);
        @(negedge clk);
        chk("cap_gnt0_drop", gnt0, 0);
        rw0 = 1'b1; addr0 = 5'd8; last0 = 1'b0;
        exp_gnt(1, cyc + 1);
        q_rd1.push_back(mk(5'd2, ref_mem[2], cyc + 3));
        exp_gnt(0, cyc + 3);
        repeat (2) @(negedge clk);
        req1 = 1'b0;
        for (int k = 8; k < 20; k++) issue(0, 1'b1, 5'(k % 18), 8'h00, (k == 19));
        @(negedge clk);
        chk("stream_end_gnt0", gnt0, 0);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_gnt1", gnt1, 0);

        // Reset the cycle after a write is accepted
        req0 = 1'b1; rw0 = 1'b1; last0 = 1'b0;
        exp_gnt(0, cyc + 1);
        issue(0, 1'b0, 5'd7, 8'h5A, 1'b0);
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("mid_rst_RB_RW", RB_RW, 1); chk("mid_rst_gnt0", gnt0, 0);
        chk("mid_rst_RB_A", RB_A, 0); chk("mid_rst_rvalid0", rvalid0, 0);

        // After reset: state IDLE and pointer back to 1, so a tie grants requester 0
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        exp_gnt(0, cyc + 1);
        @(negedge clk);
        rw0 = 1'b1; addr0 = 5'd4; last0 = 1'b0;
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("rst_cancel_rvalid0", rvalid0, 0); chk("rst_cancel_gnt0", gnt0, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        chk("left_wr", q_wr.size(), 0);   chk("left_rd0", q_rd0.size(), 0);
        chk("left_rd1", q_rd1.size(), 0); chk("left_err0", q_er0.size(), 0);
        chk("left_err1", q_er1.size(), 0); chk("left_gnt0", q_g0.size(), 0);
        chk("left_gnt1", q_g1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
